// File: rtl/tv80_bus_pkg.sv
// Shared definitions for the TV80 bus bridge: FSM state encoding, target codes
// and the default interrupt-acknowledge vector.
package tv80_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    TGT_MEM = 1'b0,
    TGT_IO  = 1'b1
  } tgt_e;

  // RST 38h opcode
  localparam logic [7:0] DEF_INT_VECTOR = 8'hFF;
  localparam logic [7:0] BUS_ERR_DATA   = 8'hFF;

endpackage

// File: rtl/tv80_bus_bridge.sv
// Turns TV80 memory / I/O bus cycles into level req / pulsed ack transactions,
// stalls the CPU with wait_n meanwhile and answers interrupt acknowledge locally.
module tv80_bus_bridge
  import tv80_bus_pkg::*;
#(
  parameter logic [7:0] INT_VECTOR = DEF_INT_VECTOR,
  parameter int         TIMEOUT    = 255,
  parameter int         CNT_W      = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m1_n,
  input  logic        i_mreq_n,
  input  logic        i_iorq_n,
  input  logic        i_rd_n,
  input  logic        i_wr_n,
  input  logic        i_rfsh_n,
  input  logic [15:0] i_a,
  input  logic [7:0]  i_cpu_dout,
  output logic [7:0]  o_cpu_di,
  output logic        o_wait_n,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_rdata,
  output logic        o_io_req,
  output logic        o_io_we,
  output logic [7:0]  o_io_addr,
  output logic [7:0]  o_io_wdata,
  input  logic        i_io_ack,
  input  logic [7:0]  i_io_rdata,
  output logic        o_bus_err
);

  localparam logic [CNT_W-1:0] L_TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  tgt_e             r_tgt;
  logic             r_we;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_cpu_di;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [15:0]      r_mem_addr;
  logic [7:0]       r_mem_wdata;
  logic             r_io_req;
  logic             r_io_we;
  logic [7:0]       r_io_addr;
  logic [7:0]       r_io_wdata;
  logic             r_bus_err;

  logic       w_mem_acc;
  logic       w_io_acc;
  logic       w_int_ack;
  logic       w_bus_idle;
  logic       w_ack;
  logic [7:0] w_rdata;
  logic       w_timeout;

  assign w_mem_acc  = !i_mreq_n && i_rfsh_n && (!i_rd_n || !i_wr_n);
  assign w_io_acc   = !i_iorq_n && i_m1_n && (!i_rd_n || !i_wr_n);
  assign w_int_ack  = !i_iorq_n && !i_m1_n;
  assign w_bus_idle = i_mreq_n && i_iorq_n && i_rd_n && i_wr_n;

  // Only the selected target's handshake is ever looked at.
  assign w_ack     = (r_tgt == TGT_IO) ? i_io_ack : i_mem_ack;
  assign w_rdata   = (r_tgt == TGT_IO) ? i_io_rdata : i_mem_rdata;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == L_TO_LAST);

  assign o_wait_n = i_reset ? 1'b1 :
                    !(((r_state == ST_IDLE) && (w_mem_acc || w_io_acc)) || (r_state == ST_REQ));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; DONE waits for every strobe to go high so one CPU cycle is one transaction.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_int_ack) begin
          w_state_nxt = ST_DONE;
        end else if (w_io_acc || w_mem_acc) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (w_ack || w_timeout) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_DONE: begin
        if (w_bus_idle) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latches, timeout counter, read-data return and error pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tgt       <= TGT_MEM;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_cpu_di    <= 8'hFF;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 8'h00;
      r_io_req    <= 1'b0;
      r_io_we     <= 1'b0;
      r_io_addr   <= 8'h00;
      r_io_wdata  <= 8'h00;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_int_ack) begin
            r_cpu_di <= INT_VECTOR;
          end else if (w_io_acc) begin
            r_tgt      <= TGT_IO;
            r_we       <= !i_wr_n;
            r_cnt      <= '0;
            r_io_req   <= 1'b1;
            r_io_we    <= !i_wr_n;
            r_io_addr  <= i_a[7:0];
            r_io_wdata <= i_cpu_dout;
          end else if (w_mem_acc) begin
            r_tgt       <= TGT_MEM;
            r_we        <= !i_wr_n;
            r_cnt       <= '0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= !i_wr_n;
            r_mem_addr  <= i_a;
            r_mem_wdata <= i_cpu_dout;
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // A late ack beats the timeout when both land on the same edge.
          if (w_ack) begin
            r_mem_req <= 1'b0;
            r_io_req  <= 1'b0;
            if (!r_we) begin
              r_cpu_di <= w_rdata;
            end
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_io_req  <= 1'b0;
            r_bus_err <= 1'b1;
            if (!r_we) begin
              r_cpu_di <= BUS_ERR_DATA;
            end
          end
        end
        ST_DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_io_req  <= 1'b0;
        end
      endcase
    end
  end

  assign o_cpu_di    = r_cpu_di;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_io_req    = r_io_req;
  assign o_io_we     = r_io_we;
  assign o_io_addr   = r_io_addr;
  assign o_io_wdata  = r_io_wdata;
  assign o_bus_err   = r_bus_err;

endmodule
